fir2d_systolic_cfg: RTL and testbench
=====================================

Name: fir2d_systolic_cfg

Overview:
Parametrised K×K 2D FIR filter built from per-row systolic multiply-accumulate chains and an output adder tree.
- Each cycle it takes one column of K vertically adjacent pixels and produces one saturated output pixel.
- Unlike the fixed 5×5 filter, coefficients are runtime-loadable through a shadow/active double bank with a safe commit, and output rounding is selectable.
- Sits between the line-buffer block, which supplies the K-row column, and the frame writer.

Parameters:
TAPS, 5, kernel size K (rows = columns), 2..9
PIX_W, 8, unsigned pixel width
COEF_W, 17, signed coefficient width (two's complement)
FRAC_BITS, 8, fractional bits of coefficients (1.0 = 1<<FRAC_BITS)
ACC_W, 40, signed accumulator width; must hold PIX_W+COEF_W+2*clog2(TAPS)+1 bits
ROUND, 1, 0 = truncate toward −inf, 1 = round half up

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
in_valid  in  1  pix_in column valid
pix_in  in  TAPS*PIX_W  row r pixel at [r*PIX_W +: PIX_W], row 0 = top
cfg_we  in  1  write cfg_data into shadow bank at cfg_addr
cfg_addr  in  clog2(TAPS*TAPS)  coefficient index r*TAPS+c
cfg_data  in  COEF_W  signed coefficient
cfg_commit  in  1  request copy of shadow bank to active bank
commit_pending  out  1  commit accepted but not yet applied
out_pixel  out  PIX_W  filtered, saturated pixel
out_valid  out  1  out_pixel valid

Behaviour:
- Reset state: out_pixel=0, out_valid=0, commit_pending=0, all pipeline registers 0. Both banks hold the identity kernel: centre index (TAPS/2)*TAPS+TAPS/2 = 1<<FRAC_BITS, all others 0.
- Datapath is free-running: no stall, every cycle is a time step. The horizontal window spans the last TAPS cycles regardless of in_valid, so upstream delivers rows as contiguous bursts.
- Function: acc(t) = Σ_{r,c} active[r*TAPS+c] * row_r(t−c), with c=0 the newest column. Pixels are zero-extended; products are signed and sign-extended to ACC_W.
- Latency: LAT = 2*TAPS+2 cycles, fixed (12 for TAPS=5). Per-row systolic chain: one multiply register and one add register per tap, operand delay 2 per tap except tap 0. Then a registered row adder tree, then the output register.
- out_valid = in_valid delayed exactly LAT cycles through a shift register; gaps are preserved 1:1.
- Scaling, on the full-precision ACC_W accumulator:
  - ROUND=1: s = (acc + (1<<(FRAC_BITS−1))) >>> FRAC_BITS.
  - ROUND=0: s = acc >>> FRAC_BITS.
  - out_pixel = 0 if s<0; 2^PIX_W−1 if s>2^PIX_W−1; else s[PIX_W−1:0].
- Coefficient write: cfg_we updates the shadow bank only, on the same edge. cfg_addr ≥ TAPS*TAPS is ignored.
- Commit state machine, states IDLE / PEND:
  - busy = any bit set in the in_valid delay line, or in_valid=1.
  - IDLE, cfg_commit=1, busy=0: copy shadow→active this edge, stay IDLE.
  - IDLE, cfg_commit=1, busy=1: go to PEND; commit_pending=1.
  - PEND: on the first edge with busy=0, copy and return to IDLE; commit_pending drops on that edge.
  - cfg_commit while in PEND: no effect, no queueing.
  - cfg_we in the same cycle as the copy edge: the copy includes the new value, i.e. write then copy.
  - Writes while in PEND: land in the shadow bank and are included in the eventual copy.
- Active coefficients never change while any valid sample is in flight. Every output uses exactly one kernel.
- Reset mid-operation clears the delay line, pipeline, PEND state and both banks, restoring identity. No out_valid appears for samples accepted before reset.

Test Plan:
1. Identity kernel after reset; a burst of 10 columns with every row = 0x80 → out_valid high for 10 cycles starting LAT=12 cycles after the first in_valid; out_pixel=0x80 each cycle.
2. Load all 25 coefficients = −1.0 (0x1FF00) and commit while idle; all pixels 0x10 → out_pixel=0x00, negative saturation. Reload all = +1.0 with pixels 0x20 → sum 800 → out_pixel=0xFF.
3. Rounding: centre coefficient = 0x00080 (0.5), others 0; centre pixel 3 → ROUND=1 gives 0x02, ROUND=0 gives 0x01. Pixel 4 → 0x02 in both.
4. Assert cfg_commit mid-burst → commit_pending=1. Outputs for the burst still use the old kernel. The copy occurs on the first edge with busy=0 (LAT cycles after the last in_valid), and commit_pending then falls.
5. in_valid pattern 1,0,1,1,0 → out_valid 1,0,1,1,0 exactly LAT cycles later. cfg_addr=25 write → kernel unchanged.
6. Assert rst for 1 cycle mid-burst after loading a custom kernel → out_valid=0 and out_pixel=0 next cycle; no stale valid outputs; a subsequent constant-0x40 burst returns 0x40 (identity restored).

Source files
------------

// File: rtl/fir2d_systolic_cfg.sv
// K x K 2D FIR: one systolic MAC chain per kernel row, a registered row-sum
// stage, a latency-matching delay, then rounding/saturation to a pixel.
// Coefficients live in a shadow bank and are copied to the active bank only
// when no valid sample is in flight, so every output uses one kernel.

// One kernel row. Pixels walk through 2 registers per tap and partial sums
// through 1, so tap c multiplies the column that is c cycles older.
module fir2d_systolic_cfg_row #(
  parameter int TAPS   = 5,
  parameter int PIX_W  = 8,
  parameter int COEF_W = 17,
  parameter int ACC_W  = 40
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [PIX_W-1:0]         pix,
  input  logic [TAPS*COEF_W-1:0]   coef,
  output logic [ACC_W-1:0]         sum
);
  localparam int XD = 2*TAPS-2;

  logic [XD-1:0][PIX_W-1:0]   xd_q, xd_d;
  logic [TAPS-1:0][PIX_W-1:0] opnd;
  logic [TAPS-1:0][ACC_W-1:0] prod, mul_q, mul_d, add_q, add_d;

  // sign-extended coefficient times zero-extended pixel, full accumulator width
  for (genvar c = 0; c < TAPS; c++) begin : g_tap
    logic [COEF_W-1:0]        cf;
    logic signed [ACC_W-1:0]  coef_x, pix_x;
    assign cf     = coef[c*COEF_W +: COEF_W];
    assign coef_x = {{(ACC_W-COEF_W){cf[COEF_W-1]}}, cf};
    assign pix_x  = {{(ACC_W-PIX_W){1'b0}}, opnd[c]};
    assign prod[c] = coef_x * pix_x;
  end

  // operand delay line, product registers and the partial-sum chain
  always_comb begin
    xd_d    = xd_q;
    xd_d[0] = pix;
    for (int i = 1; i < XD; i++) xd_d[i] = xd_q[i-1];
    opnd    = '0;
    opnd[0] = pix;
    for (int c = 1; c < TAPS; c++) opnd[c] = xd_q[2*c-1];
    mul_d    = prod;
    add_d    = '0;
    add_d[0] = mul_q[0];
    for (int c = 1; c < TAPS; c++) add_d[c] = add_q[c-1] + mul_q[c];
  end

  // pipeline registers
  always_ff @(posedge clk) begin
    if (rst) begin
      xd_q  <= '0;
      mul_q <= '0;
      add_q <= '0;
    end else begin
      xd_q  <= xd_d;
      mul_q <= mul_d;
      add_q <= add_d;
    end
  end

  assign sum = add_q[TAPS-1];
endmodule

module fir2d_systolic_cfg #(
  parameter int TAPS      = 5,
  parameter int PIX_W     = 8,
  parameter int COEF_W    = 17,
  parameter int FRAC_BITS = 8,
  parameter int ACC_W     = 40,
  parameter int ROUND     = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  input  logic [TAPS*PIX_W-1:0]          pix_in,
  input  logic                           cfg_we,
  input  logic [$clog2(TAPS*TAPS)-1:0]   cfg_addr,
  input  logic [COEF_W-1:0]              cfg_data,
  input  logic                           cfg_commit,
  output logic                           commit_pending,
  output logic [PIX_W-1:0]               out_pixel,
  output logic                           out_valid
);
  localparam int NC     = TAPS*TAPS;
  localparam int LAT    = 2*TAPS+2;
  localparam int CENTER = (TAPS/2)*TAPS + TAPS/2;

  typedef logic [NC-1:0][COEF_W-1:0] bank_t;
  typedef enum logic {IDLE, PEND} state_t;

  // identity kernel: 1.0 at the centre tap
  localparam bank_t IDENT = bank_t'(1) << (CENTER*COEF_W + FRAC_BITS);
  localparam logic signed [ACC_W-1:0] RND_ADD = ACC_W'(ROUND) << (FRAC_BITS-1);
  localparam logic signed [ACC_W-1:0] PIX_MAX = ACC_W'((1 << PIX_W) - 1);

  bank_t                       shadow_q, shadow_d, active_q, active_d;
  state_t                      state_q, state_d;
  logic [LAT-1:0]              vld_pipe_q, vld_pipe_d;
  logic [TAPS-1:0][ACC_W-1:0]  row_sum, acc_q, acc_d;
  logic [PIX_W-1:0]            out_pixel_q, out_pixel_d;
  logic                        busy;
  logic signed [ACC_W-1:0]     rnd, scl;

  // coefficient write (shadow) and the deferred shadow->active commit
  always_comb begin
    busy       = in_valid | (|vld_pipe_q);
    vld_pipe_d = {vld_pipe_q[LAT-2:0], in_valid};
    shadow_d   = shadow_q;
    active_d   = active_q;
    state_d    = state_q;
    if (cfg_we && int'(cfg_addr) < NC) shadow_d[cfg_addr] = cfg_data;
    case (state_q)
      IDLE: if (cfg_commit) begin
        if (busy) state_d = PEND;
        else      active_d = shadow_d;
      end
      PEND: if (!busy) begin
        active_d = shadow_d;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  for (genvar r = 0; r < TAPS; r++) begin : g_row
    fir2d_systolic_cfg_row #(
      .TAPS(TAPS), .PIX_W(PIX_W), .COEF_W(COEF_W), .ACC_W(ACC_W)
    ) u_row (
      .clk  (clk),
      .rst  (rst),
      .pix  (pix_in[r*PIX_W +: PIX_W]),
      .coef (active_q[r*TAPS +: TAPS]),
      .sum  (row_sum[r])
    );
  end

  // row adder stage followed by a delay that pads total latency to LAT
  always_comb begin
    acc_d = '0;
    for (int r = 0; r < TAPS; r++) acc_d[0] = acc_d[0] + row_sum[r];
    for (int i = 1; i < TAPS; i++) acc_d[i] = acc_q[i-1];
  end

  // scale to integer pixel (floor or round-half-up), then clamp to range
  always_comb begin
    rnd = $signed(acc_q[TAPS-1]) + RND_ADD;
    scl = rnd >>> FRAC_BITS;
    if (scl[ACC_W-1])       out_pixel_d = '0;
    else if (scl > PIX_MAX) out_pixel_d = '1;
    else                    out_pixel_d = scl[PIX_W-1:0];
  end

  // state, banks, valid shift register and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q    <= IDENT;
      active_q    <= IDENT;
      state_q     <= IDLE;
      vld_pipe_q  <= '0;
      acc_q       <= '0;
      out_pixel_q <= '0;
    end else begin
      shadow_q    <= shadow_d;
      active_q    <= active_d;
      state_q     <= state_d;
      vld_pipe_q  <= vld_pipe_d;
      acc_q       <= acc_d;
      out_pixel_q <= out_pixel_d;
    end
  end

  assign commit_pending = (state_q == PEND);
  assign out_valid      = vld_pipe_q[LAT-1];
  assign out_pixel      = out_pixel_q;
endmodule

// File: tb/tb_fir2d_systolic_cfg.sv
// Bench for fir2d_systolic_cfg: two instances (round / truncate) share
// inputs; a window-sum reference model with its own kernel banks predicts
// every output LAT cycles ahead.
module tb_fir2d_systolic_cfg;
  localparam int TAPS = 5, PIX_W = 8, COEF_W = 17, FRAC = 8, ACC_W = 40;
  localparam int NC = TAPS*TAPS, LAT = 2*TAPS+2, AW = $clog2(NC);
  localparam int ONE = 1 << FRAC;

  logic clk = 0, rst = 1, in_valid = 0, cfg_we = 0, cfg_commit = 0;
  logic [TAPS*PIX_W-1:0] pix_in = '0;
  logic [AW-1:0]         cfg_addr = '0;
  logic [COEF_W-1:0]     cfg_data = '0;
  logic                  pend1, pend0, ov1, ov0;
  logic [PIX_W-1:0]      op1, op0;

  always #5 clk = ~clk;

  fir2d_systolic_cfg #(.TAPS(TAPS), .PIX_W(PIX_W), .COEF_W(COEF_W),
    .FRAC_BITS(FRAC), .ACC_W(ACC_W), .ROUND(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .pix_in(pix_in),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_commit(cfg_commit), .commit_pending(pend1),
    .out_pixel(op1), .out_valid(ov1));

  fir2d_systolic_cfg #(.TAPS(TAPS), .PIX_W(PIX_W), .COEF_W(COEF_W),
    .FRAC_BITS(FRAC), .ACC_W(ACC_W), .ROUND(0)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .pix_in(pix_in),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_commit(cfg_commit), .commit_pending(pend0),
    .out_pixel(op0), .out_valid(ov0));

  // reference model state
  typedef struct { bit v; int p1; int p0; } exp_t;
  exp_t q[$];
  int   hist[TAPS][TAPS];   // hist[c][r], c = 0 is the newest column
  int   act[NC], shd[NC];
  bit   pend;
  int   cyc, last_v;
  int   n_cmp = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  function automatic int sat(input longint a, input bit rnd);
    longint s;
    if (rnd) s = (a + (longint'(1) << (FRAC-1))) >>> FRAC;
    else     s = a >>> FRAC;
    if (s < 0)   return 0;
    if (s > 255) return 255;
    return int'(s);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < TAPS; c++) for (int r = 0; r < TAPS; r++) hist[c][r] = 0;
    for (int i = 0; i < NC; i++) begin act[i] = 0; shd[i] = 0; end
    act[(TAPS/2)*TAPS + TAPS/2] = ONE;
    shd[(TAPS/2)*TAPS + TAPS/2] = ONE;
    pend = 0;
    last_v = -1000;
    q.delete();
    for (int i = 0; i < LAT-1; i++) q.push_back('{0, 0, 0});
  endtask

  // one clock: predict from current inputs, update banks, check after edge
  task automatic cycle();
    longint acc;
    exp_t e, o;
    bit busy;
    for (int c = TAPS-1; c > 0; c--) for (int r = 0; r < TAPS; r++) hist[c][r] = hist[c-1][r];
    for (int r = 0; r < TAPS; r++) hist[0][r] = int'(pix_in[r*PIX_W +: PIX_W]);
    acc = 0;
    for (int r = 0; r < TAPS; r++)
      for (int c = 0; c < TAPS; c++) acc += longint'(act[r*TAPS+c]) * hist[c][r];
    e.v = in_valid; e.p1 = sat(acc, 1); e.p0 = sat(acc, 0);
    q.push_back(e);
    busy = in_valid || (cyc - last_v <= LAT);
    if (in_valid) last_v = cyc;
    if (cfg_we && int'(cfg_addr) < NC) shd[cfg_addr] = int'($signed(cfg_data));
    if (!pend) begin
      if (cfg_commit) begin
        if (busy) pend = 1;
        else act = shd;
      end
    end else if (!busy) begin
      act = shd;
      pend = 0;
    end
    @(posedge clk); #1;
    cyc++;
    o = q.pop_front();
    chk("out_valid", ov1, o.v);
    chk("out_valid_trunc", ov0, o.v);
    chk("commit_pending", pend1, pend);
    chk("commit_pending_trunc", pend0, pend);
    if (o.v) begin
      chk("out_pixel_round", op1, o.p1);
      chk("out_pixel_trunc", op0, o.p0);
    end
  endtask

  task automatic do_reset();
    rst = 1;
    @(posedge clk); #1;
    cyc++;
    model_reset();
    rst = 0;
    chk("rst_out_valid", ov1, 0);
    chk("rst_out_pixel", op1, 0);
    chk("rst_pending", pend1, 0);
    chk("rst_out_pixel_trunc", op0, 0);
  endtask

  task automatic set_all(input int v);
    for (int r = 0; r < TAPS; r++) pix_in[r*PIX_W +: PIX_W] = PIX_W'(v);
  endtask

  task automatic burst(input int n, input int v);
    in_valid = 1;
    for (int i = 0; i < n; i++) begin
      if (v < 0) pix_in = {$urandom, $urandom};
      else set_all(v);
      cycle();
    end
    in_valid = 0;
  endtask

  task automatic idle(input int n);
    in_valid = 0;
    for (int i = 0; i < n; i++) begin pix_in = {$urandom, $urandom}; cycle(); end
  endtask

  task automatic wr(input int a, input int d);
    cfg_we = 1; cfg_addr = AW'(a); cfg_data = COEF_W'(d);
    cycle();
    cfg_we = 0;
  endtask

  task automatic load_all(input int d, input bit rnd_coef);
    for (int i = 0; i < NC; i++) wr(i, rnd_coef ? ($urandom_range(96) - 48) : d);
  endtask

  task automatic commit();
    cfg_commit = 1; cycle(); cfg_commit = 0;
  endtask

  initial begin
    cyc = 0;
    model_reset();
    @(posedge clk); #1;
    do_reset();

    // identity kernel, constant burst
    burst(10, 'h80);
    idle(LAT+3);

    // all -1.0 with small pixels saturates low; all +1.0 with 0x20 saturates high
    load_all(-ONE, 0);
    commit();
    burst(8, 'h10);
    idle(LAT+2);
    load_all(ONE, 0);
    commit();
    burst(8, 'h20);
    idle(LAT+2);

    // rounding: 0.5 at the centre only
    load_all(0, 0);
    wr((TAPS/2)*TAPS + TAPS/2, 'h80);
    commit();
    burst(6, 3);
    burst(6, 4);
    idle(LAT+2);

    // commit mid-burst is deferred; writes while pending join the copy
    load_all(0, 1);
    commit();
    load_all(0, 1);
    in_valid = 1;
    for (int i = 0; i < 20; i++) begin
      pix_in = {$urandom, $urandom};
      cfg_commit = (i == 5 || i == 12);
      cfg_we = (i == 9); cfg_addr = AW'(7); cfg_data = COEF_W'(-30);
      cycle();
      if (i == 5) chk("pend_mid_burst", pend1, 1);
    end
    cfg_commit = 0; cfg_we = 0;
    idle(LAT+4);
    chk("pend_after_drain", pend1, 0);

    // gap pattern preserved; out-of-range address ignored
    begin
      bit pat [5] = '{1, 0, 1, 1, 0};
      for (int i = 0; i < 5; i++) begin
        in_valid = pat[i]; pix_in = {$urandom, $urandom}; cycle();
      end
    end
    idle(LAT+2);
    wr(25, 'h1FFFF);
    wr(31, 1234);
    commit();
    burst(8, -1);
    idle(LAT+2);

    // randomized traffic with writes and commits
    for (int i = 0; i < 600; i++) begin
      in_valid   = ($urandom_range(9) < 7);
      pix_in     = {$urandom, $urandom};
      cfg_we     = ($urandom_range(9) == 0);
      cfg_addr   = AW'($urandom_range(31));
      cfg_data   = COEF_W'($urandom_range(96) - 48);
      cfg_commit = ($urandom_range(19) == 0);
      cycle();
      if (i % 97 == 96) idle(LAT+1);
    end
    cfg_we = 0; cfg_commit = 0;
    idle(LAT+2);

    // reset mid-burst after a custom kernel restores identity
    load_all(0, 1);
    commit();
    burst(6, -1);
    in_valid = 1;
    do_reset();
    in_valid = 0;
    idle(3);
    burst(12, 'h40);
    idle(LAT+3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
